// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp -- instruction-memory responder for the fetch interface.
//
// Accepts one fetch byte address at a time on a valid/ready request channel.
// Returns the addressed 32-bit instruction word LATENCY cycles after acceptance
// on a valid/ready response channel. Misaligned or out-of-range fetches
// complete with rsp_err=1 and rsp_data=0. A separate write port fills the
// instruction array. The array is not cleared by reset.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_addr[31:0]      fetch byte address, sampled on the accepting edge
//   rsp_valid/ready     response handshake
//   rsp_data[31:0]      instruction word (0 on a fault)
//   rsp_err             misaligned or out-of-range fetch
//   wr_en/addr/data     instruction-array write port (word index)
//   fetch_count[31:0]   completed responses since reset (wraps)
module imem_fetch_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  output logic [31:0]              fetch_count
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  // Configuration sanity checks, evaluated at elaboration.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "imem_fetch_resp: LATENCY must be in 1..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "imem_fetch_resp: DEPTH must be a power of two >= 2");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $fatal(1, "imem_fetch_resp: BASE_ADDR must be word-aligned");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  logic [31:0]   mem [DEPTH];

  state_e        state_q,       state_d;
  logic [3:0]    cnt_q,         cnt_d;
  logic          err_q,         err_d;
  logic [AW-1:0] idx_q,         idx_d;
  logic          rsp_valid_q,   rsp_valid_d;
  logic [31:0]   rsp_data_q,    rsp_data_d;
  logic          rsp_err_q,     rsp_err_d;
  logic [31:0]   fetch_count_q, fetch_count_d;

  logic [31:0]   offset_s;
  logic          req_err_s;

  // The below-base test is explicit so a wrapped subtraction never looks
  // in range.
  assign offset_s  = req_addr - BASE_ADDR;
  assign req_err_s = (req_addr[1:0] != 2'b00) ||
                     (req_addr < BASE_ADDR) ||
                     ((offset_s >> 2) >= 32'(DEPTH));

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign fetch_count = fetch_count_q;

  // Instruction array write port; active in every state, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next-state and output-register logic for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    idx_d         = idx_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          err_d   = req_err_s;
          idx_d   = offset_s[AW+1:2];
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Array read here sees the pre-edge contents, so a write to the
          // same word on this edge returns the old word.
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_data_d  = err_q ? 32'h0000_0000 : mem[idx_q];
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      err_q         <= 1'b0;
      idx_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0000_0000;
      rsp_err_q     <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      idx_q         <= idx_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Directed bench for imem_fetch_resp. Instance 0 uses LATENCY=1, BASE_ADDR=0.
// Instance 1 uses LATENCY=3, BASE_ADDR=0x1000. Both instances share the
// clock, the reset and the write port.
module tb_imem_fetch_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = 10'd0;
  logic [31:0] wr_data = 32'd0;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic [31:0] fetch_count [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_fetch_resp #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_count(fetch_count[0])
  );

  imem_fetch_resp #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h0000_1000)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_count(fetch_count[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Issues one request and checks the response appears exactly lat edges
  // after the accepting edge. Returns #1 after the edge where rsp_valid rose.
  task automatic fetch(input int u, input logic [31:0] a, input int lat,
                       input logic [31:0] exp_d, input logic exp_e, input string tag);
    chk({tag, ".req_ready_idle"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1; req_addr[u] = a;
    step();
    req_valid[u] = 1'b0; req_addr[u] = 32'hFFFF_FFFF;
    for (int i = 0; i < lat; i++) begin
      chk({tag, ".valid_early"}, 32'(rsp_valid[u]), 32'd0);
      chk({tag, ".req_ready_busy"}, 32'(req_ready[u]), 32'd0);
      step();
    end
    chk({tag, ".rsp_valid"}, 32'(rsp_valid[u]), 32'd1);
    chk({tag, ".rsp_data"}, rsp_data[u], exp_d);
    chk({tag, ".rsp_err"}, 32'(rsp_err[u]), 32'(exp_e));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_addr[u] = 32'd0; rsp_ready[u] = 1'b0;
    end
    #3;
    chk("rst.req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst.rsp_data", rsp_data[0], 32'd0);
    chk("rst.rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("rst.fetch_count", fetch_count[0], 32'd0);
    #10 rst_n = 1'b1;

    // 1: back-to-back fetches at LATENCY=1.
    wr(10'd0, 32'h0000_0013);
    wr(10'd1, 32'h00A0_0093);
    rsp_ready[0] = 1'b1;
    fetch(0, 32'h0000_0000, 1, 32'h0000_0013, 1'b0, "t1.f0");
    step();
    fetch(0, 32'h0000_0004, 1, 32'h00A0_0093, 1'b0, "t1.f1");
    step();
    chk("t1.fetch_count", fetch_count[0], 32'd2);
    chk("t1.rsp_valid_low", 32'(rsp_valid[0]), 32'd0);

    // 2: LATENCY=3, word 2 at byte 0x1008.
    wr(10'd2, 32'hDEAD_BEEF);
    rsp_ready[1] = 1'b1;
    fetch(1, 32'h0000_1008, 3, 32'hDEAD_BEEF, 1'b0, "t2");
    step();
    chk("t2.fetch_count", fetch_count[1], 32'd1);
    chk("t2.req_ready", 32'(req_ready[1]), 32'd1);

    // 3: backpressure holds the response for 5 cycles.
    rsp_ready[1] = 1'b0;
    fetch(1, 32'h0000_1008, 3, 32'hDEAD_BEEF, 1'b0, "t3");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3.hold_valid", 32'(rsp_valid[1]), 32'd1);
      chk("t3.hold_data", rsp_data[1], 32'hDEAD_BEEF);
      chk("t3.hold_err", 32'(rsp_err[1]), 32'd0);
      chk("t3.hold_count", fetch_count[1], 32'd1);
      chk("t3.hold_req_ready", 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    step();
    chk("t3.valid_drop", 32'(rsp_valid[1]), 32'd0);
    chk("t3.fetch_count", fetch_count[1], 32'd2);
    chk("t3.req_ready", 32'(req_ready[1]), 32'd1);

    // 4: fault detection with BASE_ADDR=0x1000.
    fetch(1, 32'h0000_1002, 3, 32'h0000_0000, 1'b1, "t4.misalign");
    step();
    fetch(1, 32'h0000_2000, 3, 32'h0000_0000, 1'b1, "t4.above");
    step();
    fetch(1, 32'h0000_0FFC, 3, 32'h0000_0000, 1'b1, "t4.below");
    step();
    fetch(1, 32'h0000_0008, 3, 32'h0000_0000, 1'b1, "t4.far_below");
    step();
    wr(10'd1023, 32'hCAFE_F00D);
    fetch(1, 32'h0000_1FFC, 3, 32'hCAFE_F00D, 1'b0, "t4.last");
    step();
    chk("t4.fetch_count", fetch_count[1], 32'd7);

    // 5: write on the capture edge returns the old word.
    req_valid[1] = 1'b1; req_addr[1] = 32'h0000_1008;
    step();
    req_valid[1] = 1'b0;
    step();
    step();
    wr_en = 1'b1; wr_addr = 10'd2; wr_data = 32'h1234_5678;
    step();
    wr_en = 1'b0;
    chk("t5.valid", 32'(rsp_valid[1]), 32'd1);
    chk("t5.old_data", rsp_data[1], 32'hDEAD_BEEF);
    step();
    fetch(1, 32'h0000_1008, 3, 32'h1234_5678, 1'b0, "t5.refetch");
    step();

    // 6: reset in WAIT and in RESP.
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0000;
    step();
    req_valid[0] = 1'b0;
    chk("t6.in_wait", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6.wait_rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("t6.wait_rst_ready", 32'(req_ready[0]), 32'd1);
    #2 rst_n = 1'b1;
    step();
    chk("t6.no_rsp_after_wait_rst", 32'(rsp_valid[0]), 32'd0);
    rsp_ready[0] = 1'b0;
    fetch(0, 32'h0000_0000, 1, 32'h0000_0013, 1'b0, "t6.pre");
    rst_n = 1'b0;
    #1;
    chk("t6.resp_rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("t6.resp_rst_data", rsp_data[0], 32'd0);
    chk("t6.resp_rst_count", fetch_count[0], 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("t6.req_ready", 32'(req_ready[0]), 32'd1);
    chk("t6.fetch_count", fetch_count[0], 32'd0);
    chk("t6.b_fetch_count", fetch_count[1], 32'd0);
    rsp_ready[0] = 1'b1;
    fetch(0, 32'h0000_0004, 1, 32'h00A0_0093, 1'b0, "t6.array_kept");
    step();
    chk("t6.count_after", fetch_count[0], 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_resp.md
Name: imem_fetch_resp

Overview:
Instruction-memory responder. It is the target end of the fetch interface whose initiator is the program counter / fetch stage. It accepts one fetch address at a time over a valid/ready request channel and returns the 32-bit instruction word after a fixed, parameterised latency over a valid/ready response channel. Misaligned and out-of-range fetches are flagged. A separate write port lets the bench or boot loader fill the instruction array.

Parameters:
DEPTH, 1024, number of 32-bit instruction words; power of two, >= 2.
LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept a request
req_addr  in  32  fetch byte address
rsp_valid  out  1  response valid
rsp_ready  in  1  initiator accepts response
rsp_data  out  32  instruction word
rsp_err  out  1  fetch fault (misaligned or out of range)
wr_en  in  1  instruction-array write enable
wr_addr  in  $clog2(DEPTH)  word index to write
wr_data  in  32  word to write
fetch_count  out  32  completed responses since reset

Behaviour:
- Reset (rst_n low, async): state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0, fetch_count=0. Array contents are not reset.
- req_ready = (state==IDLE), decoded directly from state. It is 1 during and immediately after reset.
- States: IDLE, WAIT, RESP.
- IDLE: on an edge with req_valid=1:
  - latch req_addr;
  - compute err = (addr[1:0]!=0) or (addr<BASE_ADDR) or (((addr-BASE_ADDR)>>2) >= DEPTH);
  - load cnt=LATENCY-1;
  - go to WAIT.
- WAIT:
  - cnt!=0: decrement cnt.
  - cnt==0: go to RESP and register the outputs: rsp_valid=1, rsp_err=err, rsp_data = err ? 0 : mem[index].
  - Result: rsp_valid first rises after edge k+LATENCY, where k is the accepting edge.
- RESP:
  - rsp_data and rsp_err are held stable while rsp_ready=0; no timeout.
  - On an edge with rsp_ready=1: rsp_valid=0, fetch_count+=1 (wraps 2^32-1 -> 0, counts errored responses too), state=IDLE.
  - No request is accepted in RESP. Minimum spacing between accepted requests is LATENCY+2 cycles.
- Index arithmetic: index = (addr-BASE_ADDR)>>2, truncated to $clog2(DEPTH) bits after the range check. 32-bit subtraction; addr<BASE_ADDR is checked explicitly, not via wrap.
- Write port:
  - mem[wr_addr] <= wr_data on any edge with wr_en=1, in every state.
  - Write and data capture on the same edge, same word: the captured rsp_data is the OLD word.
  - Writes on earlier edges are visible.
- Request inputs are ignored outside IDLE; req_addr need not be held after acceptance.
- rst_n asserted mid-transaction aborts it immediately: rsp_valid drops asynchronously and no response is produced. The array is preserved.
- Out-of-range LATENCY is a configuration error; an elaboration-time check halts simulation.

Test Plan:
1. Reset, then with LATENCY=1 preload mem[0]=32'h0000_0013 and mem[1]=32'h00A0_0093; request 0x0 then 0x4 with rsp_ready=1 -> rsp_valid one edge after each accept; data 0x00000013 then 0x00A00093; rsp_err=0; fetch_count=2.
2. LATENCY=3, request 0x8 (mem[2]=32'hDEAD_BEEF) -> rsp_valid rises after accept edge +3; req_ready=0 from accept until the response handshake.
3. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data=0xDEADBEEF and rsp_err held constant; fetch_count increments only on the handshake edge; req_ready returns to 1 the following cycle.
4. Faults with DEPTH=1024, BASE_ADDR=0x1000:
   - 0x1002 -> rsp_err=1, rsp_data=0.
   - 0x2000 -> rsp_err=1.
   - 0x0FFC -> rsp_err=1.
   - 0x1FFC -> rsp_err=0, returns mem[1023].
5. Write collision: wr_en to word 2 with 0x12345678 on the capture edge of a fetch of word 2 -> old 0xDEADBEEF returned; refetch returns 0x12345678.
6. Assert rst_n in WAIT and in RESP -> rsp_valid=0 at once; after release req_ready=1, fetch_count=0; array contents intact on the next fetch.
